// File: rtl/core_pkg.sv
// Core-wide rename parameters shared by the free list and its picker.
package core_pkg;

    localparam int PREGS          = 64;
    localparam int AREGS          = 32;
    localparam int FL_ALLOC_WIDTH = 2;
    localparam int FL_FREE_WIDTH  = 2;

    typedef logic [$clog2(PREGS)-1:0] preg_t;

endpackage

// File: rtl/free_list_pick.sv
// Combinational picker: returns up to NUM_PICK lowest set bits of a mask,
// lowest index first, by repeated find-first-set and clear.
module free_list_pick
    import core_pkg::*;
#(
    parameter  int NUM_REGS = PREGS,
    parameter  int NUM_PICK = FL_ALLOC_WIDTH,
    localparam int IDX_W    = $clog2(NUM_REGS),
    localparam int CNT_W    = $clog2(NUM_PICK + 1)
) (
    input  logic [NUM_REGS-1:0]             mask_i,
    input  logic [CNT_W-1:0]                cnt_i,
    output logic [NUM_PICK-1:0][IDX_W-1:0]  pick_idx_o,
    output logic [NUM_PICK-1:0]             pick_found_o
);

    logic [NUM_REGS-1:0] rem;

    // Pick k takes the lowest bit left over after picks 0..k-1 were removed.
    always_comb begin
        rem          = mask_i;
        pick_idx_o   = '0;
        pick_found_o = '0;
        for (int k = 0; k < NUM_PICK; k++) begin
            if (k < int'(cnt_i)) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (!pick_found_o[k] && rem[i]) begin
                        pick_found_o[k] = 1'b1;
                        pick_idx_o[k]   = IDX_W'(i);
                    end
                end
                if (pick_found_o[k]) rem[pick_idx_o[k]] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_port_free_list.sv
// Multi-port physical register free list for the rename stage.
// All-or-nothing group allocation, multi-port frees, one-cycle flush recovery.
// Optional: FREELIST_DBLFREE_CHECK_EN adds a sticky dbl_free_err output.
module multi_port_free_list
    import core_pkg::*;
#(
    parameter  int PHYS_REGS   = PREGS,
    parameter  int ARCH_REGS   = AREGS,
    parameter  int ALLOC_WIDTH = FL_ALLOC_WIDTH,
    parameter  int FREE_WIDTH  = FL_FREE_WIDTH,
    localparam int PHYS_W      = $clog2(PHYS_REGS),
    localparam int CNT_W       = $clog2(PHYS_REGS + 1),
    localparam int REQ_W       = $clog2(ALLOC_WIDTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ALLOC_WIDTH-1:0]         alloc_req,
    output logic [ALLOC_WIDTH-1:0]         alloc_valid,
    output logic [ALLOC_WIDTH*PHYS_W-1:0]  alloc_phys,
    output logic                           alloc_stall,
    input  logic [FREE_WIDTH-1:0]          free_en,
    input  logic [FREE_WIDTH*PHYS_W-1:0]   free_phys,
    input  logic                           flush,
    input  logic [PHYS_REGS-1:0]           flush_free_mask,
`ifdef FREELIST_DBLFREE_CHECK_EN
    output logic                           dbl_free_err,
`endif
    output logic [CNT_W-1:0]               free_count
);

    logic [PHYS_REGS-1:0]                free_mask_q, free_mask_d;
    logic [CNT_W-1:0]                    free_count_q, free_count_d;
    logic [ALLOC_WIDTH-1:0]              alloc_valid_q, alloc_valid_d;
    logic [ALLOC_WIDTH*PHYS_W-1:0]       alloc_phys_q, alloc_phys_d;
    logic                                alloc_stall_q, alloc_stall_d;

    logic [REQ_W-1:0]                    req_cnt;
    logic                                grant_ok;
    logic [ALLOC_WIDTH-1:0][PHYS_W-1:0]  pick_idx;
    logic [ALLOC_WIDTH-1:0]              pick_found;
    logic [PHYS_REGS-1:0]                grant_mask;
    logic [PHYS_REGS-1:0]                free_vec;
    logic [PHYS_REGS-1:0]                mask_post;
    logic [PHYS_REGS-1:0]                set_new;
    logic [CNT_W-1:0]                    nset;
    logic [PHYS_W-1:0]                   fidx;

    // Group size and the all-or-nothing decision against the pre-edge count.
    always_comb begin
        req_cnt = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) req_cnt += REQ_W'(alloc_req[i]);
        grant_ok = !flush && (req_cnt != '0) && (CNT_W'(req_cnt) <= free_count_q);
    end

    free_list_pick #(
        .NUM_REGS (PHYS_REGS),
        .NUM_PICK (ALLOC_WIDTH)
    ) u_pick (
        .mask_i       (free_mask_q),
        .cnt_i        (req_cnt),
        .pick_idx_o   (pick_idx),
        .pick_found_o (pick_found)
    );

    // Hand picks to requesting slots in ascending slot order; idle slots skip.
    always_comb begin
        int k;
        k             = 0;
        alloc_valid_d = '0;
        alloc_phys_d  = '0;
        grant_mask    = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            if (grant_ok && alloc_req[i]) begin
                if (pick_found[k]) begin
                    alloc_valid_d[i]                = 1'b1;
                    alloc_phys_d[i*PHYS_W +: PHYS_W] = pick_idx[k];
                    grant_mask[pick_idx[k]]         = 1'b1;
                end
                k++;
            end
        end
        alloc_stall_d = !flush && (req_cnt != '0) && !grant_ok;
    end

    // Next mask and incremental count: old count - grants + bits newly set.
    always_comb begin
        free_vec = flush ? flush_free_mask : '0;
        fidx     = '0;
        for (int j = 0; j < FREE_WIDTH; j++) begin
            fidx = free_phys[j*PHYS_W +: PHYS_W];
            if (free_en[j] && int'(fidx) < PHYS_REGS) free_vec[fidx] = 1'b1;
        end
        mask_post = free_mask_q & ~grant_mask;
        set_new   = free_vec & ~mask_post;
        nset      = '0;
        for (int i = 0; i < PHYS_REGS; i++) nset += CNT_W'(set_new[i]);
        free_mask_d  = mask_post | free_vec;
        free_count_d = free_count_q - CNT_W'(grant_ok ? req_cnt : '0) + nset;
    end

    // Core state; arch regs start allocated under the identity map.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHYS_REGS; i++) free_mask_q[i] <= (i >= ARCH_REGS);
            free_count_q  <= CNT_W'(PHYS_REGS - ARCH_REGS);
            alloc_valid_q <= '0;
            alloc_phys_q  <= '0;
            alloc_stall_q <= 1'b0;
        end else begin
            free_mask_q   <= free_mask_d;
            free_count_q  <= free_count_d;
            alloc_valid_q <= alloc_valid_d;
            alloc_phys_q  <= alloc_phys_d;
            alloc_stall_q <= alloc_stall_d;
        end
    end

    assign alloc_valid = alloc_valid_q;
    assign alloc_phys  = alloc_phys_q;
    assign alloc_stall = alloc_stall_q;
    assign free_count  = free_count_q;

`ifdef FREELIST_DBLFREE_CHECK_EN
    logic             dbl_free_err_q;
    logic             dbl_hit;
    logic [PHYS_W-1:0] eidx;

    // Flag frees of free/just-granted/out-of-range pregs and duplicate ports.
    always_comb begin
        dbl_hit = 1'b0;
        eidx    = '0;
        for (int j = 0; j < FREE_WIDTH; j++) begin
            eidx = free_phys[j*PHYS_W +: PHYS_W];
            if (free_en[j]) begin
                if (int'(eidx) >= PHYS_REGS) dbl_hit = 1'b1;
                else if (free_mask_q[eidx] || grant_mask[eidx]) dbl_hit = 1'b1;
                for (int m = 0; m < j; m++) begin
                    if (free_en[m] && free_phys[m*PHYS_W +: PHYS_W] == eidx) dbl_hit = 1'b1;
                end
            end
        end
    end

    // Sticky error, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) dbl_free_err_q <= 1'b0;
        else if (dbl_hit) dbl_free_err_q <= 1'b1;
    end

    assign dbl_free_err = dbl_free_err_q;
`endif

endmodule
